// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Ports: req0/1 valid-ready ops in, alu_* to/from ALU, rsp0/1 valid-ready results out.
module alu_arbiter #(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_d, gnt_q;
  logic        last_q;
  logic        any_req;
  logic        hs;
  logic        illegal;
  logic [3:0]  ctl_q;
  logic [31:0] a_q, b_q;
  logic [31:0] data_q;
  logic        zero_q, err_q;

  assign any_req = req0_valid | req1_valid;
  assign hs = (state_q == RESP) &&
              (gnt_q ? rsp1_ready : rsp0_ready);

  // Round-robin favours whoever did not complete last.
  always_comb begin
    gnt_d = 1'b0;
    unique case (1'b1)
      (req0_valid && req1_valid):
        gnt_d = (PRIO_MODE == 1) ? 1'b0 : ~last_q;
      (req1_valid && !req0_valid):
        gnt_d = 1'b1;
      default:
        gnt_d = 1'b0;
    endcase
  end

  always_comb begin
    illegal = 1'b1;
    case (ctl_q)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd6, 4'd7, 4'd12: illegal = 1'b0;
      default:           illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by rst_n so it drops while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (rst_n && state_q == IDLE) begin
      req0_ready = req0_valid & ~gnt_d;
      req1_ready = req1_valid &  gnt_d;
    end
    if (state_q == RESP) begin
      rsp0_valid = ~gnt_q;
      rsp1_valid =  gnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
      ctl_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && any_req) begin
        gnt_q <= gnt_d;
        ctl_q <= gnt_d ? req1_ctl : req0_ctl;
        a_q   <= gnt_d ? req1_a : req0_a;
        b_q   <= gnt_d ? req1_b : req0_b;
      end
      if (state_q == EXEC) begin
        data_q <= alu_out;
        zero_q <= alu_zero;
        err_q  <= illegal;
      end
      if (hs) last_q <= gnt_q;
    end
  end

  assign alu_ctl  = ctl_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus contention,
// backpressure and mid-operation reset sequences.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_ctl;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_ctl;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
  logic        rsp0_valid, rsp0_ready;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_err;

  logic        f_req0_ready, f_req1_ready;
  logic [3:0]  f_alu_ctl;
  logic [31:0] f_alu_a, f_alu_b, f_alu_out;
  logic        f_alu_zero;
  logic        f_rsp0_valid, f_rsp1_valid;
  logic [31:0] f_rsp_data;
  logic        f_rsp_zero, f_rsp_err;
  logic        one;

  int pass_cnt;
  int total_cnt;

  function automatic logic [31:0] alu_f(
    input logic [3:0] c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a << b[4:0];
      4'd6:    return a - b;
      4'd7:    return {31'b0, a < b};
      4'd12:   return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out    = alu_f(alu_ctl, alu_a, alu_b);
  assign alu_zero   = (alu_out == 32'd0);
  assign f_alu_out  = alu_f(f_alu_ctl, f_alu_a, f_alu_b);
  assign f_alu_zero = (f_alu_out == 32'd0);
  assign one = 1'b1;

  alu_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  alu_arbiter #(.PRIO_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(one), .req0_ready(f_req0_ready),
    .req0_ctl(4'd6), .req0_a(32'd9), .req0_b(32'd9),
    .req1_valid(one), .req1_ready(f_req1_ready),
    .req1_ctl(4'd1), .req1_a(32'hF0), .req1_b(32'h0F),
    .alu_ctl(f_alu_ctl), .alu_a(f_alu_a), .alu_b(f_alu_b),
    .alu_out(f_alu_out), .alu_zero(f_alu_zero),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(one),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(one),
    .rsp_data(f_rsp_data), .rsp_zero(f_rsp_zero), .rsp_err(f_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    bit          id;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vt[12];

  task automatic set_req(input bit id, input logic v,
                         input logic [3:0] c,
                         input logic [31:0] a,
                         input logic [31:0] b);
    if (!id) begin
      req0_valid = v; req0_ctl = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_ctl = c; req1_a = a; req1_b = b;
    end
  endtask

  task automatic run_vec(input int k);
    logic rdy;
    int   n;
    @(negedge clk);
    set_req(vt[k].id, 1'b1, vt[k].ctl, vt[k].a, vt[k].b);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    n = 0;
    rdy = vt[k].id ? req1_ready : req0_ready;
    while (!rdy && n < 10) begin
      cyc();
      n++;
      rdy = vt[k].id ? req1_ready : req0_ready;
    end
    chk($sformatf("v%0d_ready", k), {31'b0, rdy}, 32'd1);
    @(negedge clk);
    set_req(vt[k].id, 1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    chk($sformatf("v%0d_exec_ctl", k), {28'b0, alu_ctl},
        {28'b0, vt[k].ctl});
    chk($sformatf("v%0d_n1_valid", k),
        {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    cyc();
    chk($sformatf("v%0d_n2_valid", k),
        {30'b0, rsp1_valid, rsp0_valid},
        vt[k].id ? 32'd2 : 32'd1);
    chk($sformatf("v%0d_data", k), rsp_data, vt[k].data);
    chk($sformatf("v%0d_zero_err", k), {30'b0, rsp_zero, rsp_err},
        {30'b0, vt[k].zero, vt[k].err});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic flush();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int g[$];
    int fg0, fg1;
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_ctl = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctl = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    vt[0]  = '{0, 4'd2,  32'd5,        32'd7,        32'd12,       0, 0};
    vt[1]  = '{1, 4'd0,  32'hF0F0,     32'hFF00,     32'hF000,     0, 0};
    vt[2]  = '{0, 4'd1,  32'hF0,       32'h0F,       32'hFF,       0, 0};
    vt[3]  = '{1, 4'd3,  32'd1,        32'd4,        32'd16,       0, 0};
    vt[4]  = '{0, 4'd6,  32'd9,        32'd9,        32'd0,        1, 0};
    vt[5]  = '{1, 4'd6,  32'd3,        32'd5,        32'hFFFFFFFE, 0, 0};
    vt[6]  = '{0, 4'd7,  32'd3,        32'd8,        32'd1,        0, 0};
    vt[7]  = '{1, 4'd7,  32'd8,        32'd3,        32'd0,        1, 0};
    vt[8]  = '{0, 4'd12, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 0, 0};
    vt[9]  = '{0, 4'd5,  32'd1,        32'd1,        32'd0,        1, 1};
    vt[10] = '{1, 4'd15, 32'd7,        32'd7,        32'd0,        1, 1};
    vt[11] = '{0, 4'd7,  32'hFFFFFFFF, 32'd1,        32'd0,        1, 0};

    #1;
    chk("rst_alu", {alu_ctl, alu_a[27:0]} | alu_b, 32'd0);
    chk("rst_rsp", {28'b0, rsp0_valid, rsp1_valid, rsp_zero, rsp_err},
        32'd0);
    chk("rst_data", rsp_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) run_vec(k);
    flush();

    // Contention from reset: RR alternates, FP always grants 0.
    do_reset();
    set_req(1'b0, 1'b1, 4'd6, 32'd9, 32'd9);
    set_req(1'b1, 1'b1, 4'd1, 32'hF0, 32'h0F);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    fg0 = 0;
    fg1 = 0;
    #1;
    for (int c = 0; c < 20 && g.size() < 4; c++) begin
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      if (f_req0_ready) fg0++;
      if (f_req1_ready) fg1++;
      if (rsp0_valid)
        chk("cont_rsp0", {rsp_data[30:0], rsp_zero}, 32'd1);
      if (rsp1_valid)
        chk("cont_rsp1", {rsp_data[30:0], rsp_zero}, 32'h1FE);
      cyc();
    end
    chk("cont_ngrants", g.size(), 32'd4);
    if (g.size() == 4) begin
      chk("cont_order", (g[0] << 3) | (g[1] << 2) | (g[2] << 1) | g[3],
          32'b0101);
    end
    chk("fp_req1_grants", fg1, 32'd0);
    chk("fp_req0_grants", {31'b0, fg0 >= 3}, 32'd1);
    flush();

    // Backpressure on requester 1 with requester 0 waiting.
    @(negedge clk);
    set_req(1'b1, 1'b1, 4'd7, 32'd3, 32'd8);
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    chk("bp_accept", {31'b0, req1_ready}, 32'd1);
    @(negedge clk);
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1'b0, 1'b1, 4'd2, 32'd5, 32'd7);
    #1;
    chk("bp_exec_r0rdy", {31'b0, req0_ready}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk($sformatf("bp_hold%0d", c),
          {rsp_data[28:0], rsp1_valid, rsp0_valid, req0_ready},
          32'b1100);
    end
    @(negedge clk);
    rsp1_ready = 1'b1;
    #1;
    chk("bp_hs_valid", {31'b0, rsp1_valid}, 32'd1);
    cyc();
    chk("bp_idle", {30'b0, req0_ready, rsp1_valid}, 32'd2);
    @(negedge clk);
    req0_valid = 1'b0;
    cyc();
    chk("bp_r0_data", {rsp_data[30:0], rsp0_valid}, 32'd25);

    // Reset during EXEC discards the op; last grant returns to 1.
    @(negedge clk);
    set_req(1'b0, 1'b1, 4'd2, 32'd5, 32'd7);
    #1;
    chk("mr_accept", {31'b0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("mr_exec_a", alu_a, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mr_alu_zero", {28'b0, alu_ctl} | alu_a | alu_b, 32'd0);
    chk("mr_rsp_zero", {rsp_data[28:0], rsp_zero, rsp_err, rsp0_valid},
        32'd0);
    req0_valid = 1'b1;
    #1;
    chk("mr_ready_low", {31'b0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk($sformatf("mr_norsp%0d", c), {30'b0, rsp0_valid, rsp1_valid},
          32'd0);
    end
    @(negedge clk);
    set_req(1'b0, 1'b1, 4'd2, 32'd1, 32'd1);
    set_req(1'b1, 1'b1, 4'd2, 32'd2, 32'd2);
    #1;
    chk("mr_first_grant", {30'b0, req0_ready, req1_ready}, 32'd2);
    flush();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin, 1 = fixed priority with requester 0 winning.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester N has an operation pending.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 bit each: operation accepted this cycle.
REQ-006 The block SHALL have ports req0_ctl/req1_ctl, input, 4 bits each: ALU opcode (0 AND, 1 OR, 2 ADD, 3 SLL, 6 SUB, 7 SLT unsigned, 12 XOR).
REQ-007 The block SHALL have ports req0_a/req0_b/req1_a/req1_b, input, 32 bits each: operands.
REQ-008 The block SHALL have ports alu_ctl (4 bits), alu_a (32 bits), alu_b (32 bits), all outputs, driving the shared combinational ALU.
REQ-009 The block SHALL have ports alu_out (32 bits) and alu_zero (1 bit), inputs, from the shared ALU.
REQ-010 The block SHALL have ports rsp0_valid/rsp1_valid, output, 1 bit each: result available for requester N.
REQ-011 The block SHALL have ports rsp0_ready/rsp1_ready, input, 1 bit each: requester N takes the result.
REQ-012 The block SHALL have ports rsp_data (32 bits), rsp_zero (1 bit), rsp_err (1 bit), outputs, shared by both response channels.

Function
REQ-013 The block SHALL implement states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-014 In IDLE with at least one reqN_valid, the block SHALL assert exactly one reqN_ready combinationally for the granted requester, register its ctl/a/b and grant id, and enter EXEC.
REQ-015 Arbitration, both valid: PRIO_MODE=0 grants the requester not granted most recently; PRIO_MODE=1 always grants requester 0.
REQ-016 The block SHALL keep both reqN_ready low in EXEC and RESP; requesters hold valid and payload until ready.
REQ-017 In EXEC the block SHALL drive alu_ctl/alu_a/alu_b from the registered operation, capture alu_out into rsp_data and alu_zero into rsp_zero at the clock edge, and enter RESP.
REQ-018 alu_ctl/alu_a/alu_b SHALL always equal the registered operation registers (no combinational path from req inputs).
REQ-019 rsp_err SHALL be captured as 1 when the registered opcode is not in {0,1,2,3,6,7,12}, else 0; rsp_data then holds the ALU value (0).
REQ-020 In RESP the block SHALL assert rspN_valid for the granted id only and hold rsp_data/rsp_zero/rsp_err stable until rspN_ready is high.
REQ-021 When rspN_valid and rspN_ready are both high at an edge, the block SHALL update the last-grant record and enter IDLE.
REQ-022 Latency: operation accepted in cycle N SHALL present rspN_valid in cycle N+2; minimum issue spacing is 3 cycles.
REQ-023 rspM_ready for the non-granted requester SHALL be ignored.

Reset
REQ-024 On rst_n low, regardless of state, the block SHALL enter IDLE immediately, clear all reqN_ready/rspN_valid, and zero rsp_data, rsp_zero, rsp_err, alu_ctl, alu_a, alu_b.
REQ-025 Reset SHALL set the last-grant record to requester 1 so requester 0 wins the first contested arbitration.
REQ-026 An operation in flight at reset SHALL be discarded with no response issued.

Verification
REQ-027 Single op: req0 ADD a=5 b=7 accepted cycle N -> rsp0_valid cycle N+2, rsp_data=12, rsp_zero=0, rsp_err=0.
REQ-028 Contention, PRIO_MODE=0: both valid continuously from reset (req0 SUB 9,9; req1 OR 0xF0,0x0F), rsp_ready tied high -> grants 0,1,0,1; rsp0 data 0 with zero=1, rsp1 data 0xFF.
REQ-029 Contention, PRIO_MODE=1: both valid continuously -> req1 never granted while req0_valid stays high.
REQ-030 Backpressure: req1 SLT a=3 b=8, rsp1_ready low 5 cycles -> rsp1_valid held, rsp_data=1 stable, req0_ready low throughout; IDLE one cycle after handshake.
REQ-031 Illegal opcode: req0 ctl=5 a=1 b=1 -> rsp_data=0, rsp_zero=1, rsp_err=1.
REQ-032 Reset mid-operation: rst_n low during EXEC -> outputs zero asynchronously, no rsp_valid after release, next contested grant goes to requester 0.
